// File: rtl/iob_pcie_tx_arbiter_pkg.sv
// iob_pcie_tx_arbiter_pkg: shared state encoding and beat-size helper for the PCIe TX arbiter
package iob_pcie_tx_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DATA = 2'd2, DONE = 2'd3} tx_state_e;
  function automatic int beat_words(input int dw);
    return dw / 32;
  endfunction
endpackage

// File: rtl/iob_pcie_rr_arbiter.sv
// iob_pcie_rr_arbiter: combinational round-robin pick, first request above ptr_i with wrap
module iob_pcie_rr_arbiter #(
  parameter int N = 2,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o
);
  // Scan farthest candidate first so the nearest one after ptr_i overwrites it.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int k = N; k >= 1; k--) begin
      if (req_i[W'((int'(ptr_i) + k) % N)]) begin
        gnt_o = '0;
        gnt_o[W'((int'(ptr_i) + k) % N)] = 1'b1;
        idx_o = W'((int'(ptr_i) + k) % N);
      end
    end
  end
endmodule

// File: rtl/iob_pcie_tx_arbiter.sv
// iob_pcie_tx_arbiter: round-robin sharing of one RIFFA PCIe TX channel among NUM_REQ requesters
module iob_pcie_tx_arbiter
  import iob_pcie_tx_arbiter_pkg::*;
#(
  parameter int C_PCI_DATA_WIDTH = 32,
  parameter int NUM_REQ = 2
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic [NUM_REQ-1:0]                  REQ_TX,
  input  logic [NUM_REQ-1:0]                  REQ_LAST,
  input  logic [32*NUM_REQ-1:0]               REQ_LEN,
  input  logic [31*NUM_REQ-1:0]               REQ_OFF,
  input  logic [C_PCI_DATA_WIDTH*NUM_REQ-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]                  REQ_DATA_VALID,
  output logic [NUM_REQ-1:0]                  REQ_DATA_REN,
  output logic [NUM_REQ-1:0]                  REQ_DONE,
  output logic [NUM_REQ-1:0]                  GRANT,
  output logic                                CHNL_TX_CLK,
  output logic                                CHNL_TX,
  input  logic                                CHNL_TX_ACK,
  output logic                                CHNL_TX_LAST,
  output logic [31:0]                         CHNL_TX_LEN,
  output logic [30:0]                         CHNL_TX_OFF,
  output logic [C_PCI_DATA_WIDTH-1:0]         CHNL_TX_DATA,
  output logic                                CHNL_TX_DATA_VALID,
  input  logic                                CHNL_TX_DATA_REN
);
  localparam int W = $clog2(NUM_REQ);
  localparam int BW = beat_words(C_PCI_DATA_WIDTH);
  tx_state_e            state_q;
  logic [NUM_REQ-1:0]   grant_q, win_gnt;
  logic [W-1:0]         idx_q, ptr_q, win_idx;
  logic [31:0]          len_q, count_q;
  logic [30:0]          off_q;
  logic                 last_q, in_data, beat, reach;
  iob_pcie_rr_arbiter #(.N(NUM_REQ), .W(W)) u_rr (
    .req_i(REQ_TX),
    .ptr_i(ptr_q),
    .gnt_o(win_gnt),
    .idx_o(win_idx)
  );
  assign in_data            = state_q == DATA;
  assign CHNL_TX_CLK        = CLK;
  assign CHNL_TX            = state_q == REQ || in_data;
  assign CHNL_TX_DATA       = in_data ? REQ_DATA[C_PCI_DATA_WIDTH*int'(idx_q) +: C_PCI_DATA_WIDTH] : '0;
  assign CHNL_TX_DATA_VALID = in_data & REQ_DATA_VALID[idx_q];
  assign REQ_DATA_REN       = (in_data && CHNL_TX_DATA_REN) ? grant_q : '0;
  assign REQ_DONE           = state_q == DONE ? grant_q : '0;
  assign GRANT              = grant_q;
  assign CHNL_TX_LEN        = len_q;
  assign CHNL_TX_OFF        = off_q;
  assign CHNL_TX_LAST       = last_q;
  assign beat               = CHNL_TX_DATA_VALID & CHNL_TX_DATA_REN;
  // 33-bit compare so a length near 2^32 can never wrap the count past it.
  assign reach              = ({1'b0, count_q} + 33'(BW)) >= {1'b0, len_q};
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= W'(NUM_REQ - 1);
      len_q   <= '0;
      off_q   <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (|REQ_TX) begin
          state_q <= REQ;
          grant_q <= win_gnt;
          idx_q   <= win_idx;
          len_q   <= REQ_LEN[32*int'(win_idx) +: 32];
          off_q   <= REQ_OFF[31*int'(win_idx) +: 31];
          last_q  <= REQ_LAST[win_idx];
          count_q <= '0;
        end
        REQ: if (CHNL_TX_ACK) state_q <= len_q == 32'd0 ? DONE : DATA;
        DATA: if (beat) begin
          count_q <= count_q + 32'(BW);
          if (reach) state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          ptr_q   <= idx_q;
        end
      endcase
    end
  end
endmodule

// File: doc/iob_pcie_tx_arbiter.md
Name: iob_pcie_tx_arbiter

Overview:
Shares one RIFFA-style PCIe TX channel between NUM_REQ local requesters.
- Round-robin grant among pending requests.
- Runs the channel handshake: CHNL_TX until ACK, then stream until the length is reached.
- Muxes the winner's data onto the channel and returns read-enables and a completion pulse to the winner only.
- Sits between the user cores and the channel TX port of the PCIe core.

Parameters:
C_PCI_DATA_WIDTH, 32, channel data width in bits (32/64/128); beat = C_PCI_DATA_WIDTH/32 words.
NUM_REQ, 2, number of requesters (2..8).

Ports:
CLK  in  1  single clock for all logic; also driven out on CHNL_TX_CLK.
RST  in  1  asynchronous, active-high reset.
REQ_TX  in  NUM_REQ  per-requester transfer request; sampled only in IDLE.
REQ_LAST  in  NUM_REQ  per-requester LAST flag.
REQ_LEN  in  32*NUM_REQ  per-requester length in 32-bit words; slice i = [32*i+31:32*i].
REQ_OFF  in  31*NUM_REQ  per-requester offset.
REQ_DATA  in  C_PCI_DATA_WIDTH*NUM_REQ  per-requester data.
REQ_DATA_VALID  in  NUM_REQ  per-requester data valid.
REQ_DATA_REN  out  NUM_REQ  read enable; only the granted bit may be high.
REQ_DONE  out  NUM_REQ  one-cycle completion pulse to the granted requester.
GRANT  out  NUM_REQ  one-hot current owner; zero in IDLE.
CHNL_TX_CLK  out  1  equals CLK.
CHNL_TX  out  1  channel transfer request.
CHNL_TX_ACK  in  1  channel acknowledge.
CHNL_TX_LAST  out  1  latched REQ_LAST of the winner.
CHNL_TX_LEN  out  32  latched length of the winner.
CHNL_TX_OFF  out  31  latched offset of the winner.
CHNL_TX_DATA  out  C_PCI_DATA_WIDTH  muxed data of the winner.
CHNL_TX_DATA_VALID  out  1  muxed valid of the winner.
CHNL_TX_DATA_REN  in  1  channel accepts a beat.

Behaviour:
- Reset values, all asynchronous on RST: state=IDLE; GRANT=0; CHNL_TX=0; LEN/OFF/LAST=0; count=0; REQ_DATA_REN=0; REQ_DONE=0; DATA_VALID=0; CHNL_TX_DATA=0; round-robin pointer=NUM_REQ-1, so requester 0 wins first after reset.
- IDLE: if any REQ_TX is set, pick the first set index searching upward from pointer+1 with wrap.
  - Next cycle: GRANT=onehot(winner); LEN/OFF/LAST latched from the winner's slices; count=0; go to REQ.
  - No request: stay in IDLE.
- REQ: CHNL_TX=1. On CHNL_TX_ACK=1:
  - latched LEN==0 -> DONE;
  - otherwise -> DATA.
- DATA: CHNL_TX=1.
  - CHNL_TX_DATA and CHNL_TX_DATA_VALID are combinationally muxed from the winner.
  - REQ_DATA_REN[winner] = CHNL_TX_DATA_REN; all other REN bits are 0.
  - A beat is when VALID & REN are both high. On a beat, count += beat.
  - If count + beat >= LEN on that beat, go to DONE. Overshoot is allowed when LEN is not a multiple of beat.
  - No beat (either signal low): hold state and count.
- DONE:
  - CHNL_TX=0; VALID=0; REN=0.
  - REQ_DONE[winner]=1 for exactly this cycle.
  - pointer=winner; GRANT=0; next state IDLE.
- Latency:
  - request to CHNL_TX: 1 cycle;
  - last beat to REQ_DONE: 1 cycle;
  - minimum gap between transfers: DONE plus IDLE plus arbitration = 2 cycles with CHNL_TX low.
- REQ_TX is ignored outside IDLE. A requester that drops REQ_TX mid-transfer does not abort it. A requester still holding REQ_TX in IDLE re-arbitrates and loses to any other pending requester.
- Simultaneous requests: grant strictly by rotating priority; no requester is granted twice while another is pending.
- CHNL_TX_ACK outside REQ is ignored.
- Count is 32-bit unsigned; the comparison uses 33-bit arithmetic, so no wrap.
- RST mid-transfer: immediate return to the reset values; no REQ_DONE pulse.

Decomposition:
- Shared package: state encoding (IDLE=0, REQ=1, DATA=2, DONE=3) and a beat-words constant function.
- Sub-module iob_pcie_rr_arbiter: NUM_REQ request vector plus pointer in, one-hot grant and index out; purely combinational, reusable for the RX side.

Test Plan:
1. Req0 LEN=4, DW=32, ACK after 3 cycles, REN=1 -> CHNL_TX high 1 cycle after the request; 4 beats of req0 data; REQ_DONE[0] one cycle after the 4th beat; CHNL_TX low in DONE.
2. REQ_TX=2'b11 held -> grant order 0,1,0,1; each CHNL_TX_LEN/OFF matches its owner; REQ_DATA_REN[1]=0 during req0 beats.
3. Req1 LEN=0 -> ACK goes directly to DONE; zero beats; REQ_DONE[1] pulses; pointer=1.
4. LEN=8, REN toggled 1,0,0,1..., VALID gaps -> count advances only on VALID&REN; exactly 8 beats; no lost or duplicated data.
5. DW=64, LEN=5 -> 3 beats, DONE after count reaches 6.
6. RST pulsed after 2 of 6 beats -> all outputs zero asynchronously; no REQ_DONE; next grant goes to req0.
